// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared constants and types for the CPU front end.
//   DATA_W        : instruction / instruction-memory word width
//   ADDR_W        : instruction-memory word-address width (depth = 2**ADDR_W)
//   fetch_state_t : fetch unit operating mode (program load, run, halted)
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage : cpu_pkg

// File: rtl/if_pc_gen.sv
// -----------------------------------------------------------------------------
// if_pc_gen
// Program counter for the fetch unit. Holds the next sequential fetch address
// and selects between it and a branch target. After every fetch the PC moves
// to fetch address + 1; the addition wraps silently at 2**ADDR_W.
// Ports:
//   clk, reset        clock, synchronous active-high reset (PC <- RESET_PC)
//   i_fetch           a fetch is issued this cycle
//   i_branch_valid    redirect requested this cycle
//   i_branch_target   redirect address
//   o_fetch_addr      address to fetch this cycle (branch target or PC)
// -----------------------------------------------------------------------------
module if_pc_gen #(
    parameter int                ADDR_W   = cpu_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_fetch,
    input  logic              i_branch_valid,
    input  logic [ADDR_W-1:0] i_branch_target,
    output logic [ADDR_W-1:0] o_fetch_addr
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] r_pc;

    // Fetch address select: a redirect overrides the sequential PC.
    always_comb begin
        o_fetch_addr = r_pc;
        if (i_branch_valid) begin
            o_fetch_addr = i_branch_target;
        end else begin
            o_fetch_addr = r_pc;
        end
    end

    // PC register: advances past whatever address was actually fetched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (i_fetch) begin
            r_pc <= o_fetch_addr + ADDR_ONE;
        end
    end

endmodule : if_pc_gen

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Front end of the instruction memory (IM). After reset it loads a program
// into IM one word per host strobe; on start it runs the PC, issues IM reads,
// absorbs the one-cycle IM read latency and presents {inst, pc} to decode via
// a valid/ready handshake with stall, branch redirect and halt support.
// Ports:
//   clk, reset            clock, synchronous active-high reset (shared with IM)
//   i_load_valid/_data    host program write (LOAD only)
//   i_start               LOAD -> RUN
//   i_halt_req            RUN -> HALT (left only through reset)
//   i_branch_valid/target redirect from execute
//   i_inst_ready          decode accepts the presented instruction
//   o_inst_valid/_data/_pc instruction handed to decode
//   o_load_full           load pointer wrapped; further loads ignored
//   o_running             unit is in RUN
//   o_im_*                IM address/enables/write data
//   i_im_dout             IM read data, valid one cycle after a fetch strobe
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int                DATA_W   = cpu_pkg::DATA_W,
    parameter int                ADDR_W   = cpu_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load_valid,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic              i_start,
    input  logic              i_halt_req,
    input  logic              i_branch_valid,
    input  logic [ADDR_W-1:0] i_branch_target,
    input  logic              i_inst_ready,
    output logic              o_inst_valid,
    output logic [DATA_W-1:0] o_inst_data,
    output logic [ADDR_W-1:0] o_inst_pc,
    output logic              o_load_full,
    output logic              o_running,
    output logic [ADDR_W-1:0] o_im_address,
    output logic              o_im_enable_mem,
    output logic              o_im_enable_fetch,
    output logic              o_im_enable_write,
    output logic [DATA_W-1:0] o_im_din,
    input  logic [DATA_W-1:0] i_im_dout
);

    import cpu_pkg::*;

    localparam logic [ADDR_W-1:0] ADDR_ONE      = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] LOAD_PTR_LAST = {ADDR_W{1'b1}};

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_load_ptr;
    logic              r_load_full;
    logic              r_inst_valid;
    logic [ADDR_W-1:0] r_inst_pc;
    logic              w_running;
    logic              w_write;
    logic              w_fetch;
    logic [ADDR_W-1:0] w_fetch_addr;

    assign w_running = (r_state == RUN);

    if_pc_gen #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk             (clk),
        .reset           (reset),
        .i_fetch         (w_fetch),
        .i_branch_valid  (i_branch_valid),
        .i_branch_target (i_branch_target),
        .o_fetch_addr    (w_fetch_addr)
    );

    // Mode register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Mode transitions: LOAD -> RUN on start, RUN -> HALT on halt request.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LOAD: begin
                if (i_start) begin
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = LOAD;
                end
            end
            RUN: begin
                if (i_halt_req) begin
                    w_state_nxt = HALT;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            HALT:    w_state_nxt = HALT;
            default: w_state_nxt = LOAD;
        endcase
    end

    // IM strobes. Write only exists in LOAD and fetch only in RUN, so the two
    // can never coincide. A new fetch may overwrite the presented instruction
    // only when it is absent, being accepted, or being flushed by a branch.
    always_comb begin
        w_write = 1'b0;
        w_fetch = 1'b0;
        if (reset) begin
            w_write = 1'b0;
            w_fetch = 1'b0;
        end else begin
            w_write = (r_state == LOAD) & i_load_valid & ~r_load_full;
            w_fetch = w_running & ~i_halt_req &
                      (~r_inst_valid | i_inst_ready | i_branch_valid);
        end
    end

    // Program load pointer; saturates into load_full after the last word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_load_ptr  <= {ADDR_W{1'b0}};
            r_load_full <= 1'b0;
        end else if (w_write) begin
            r_load_ptr <= r_load_ptr + ADDR_ONE;
            if (r_load_ptr == LOAD_PTR_LAST) begin
                r_load_full <= 1'b1;
            end
        end
    end

    // Decode handshake. IM keeps its output stable when not read, so a
    // stalled instruction needs no local copy: only valid and pc are held.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inst_valid <= 1'b0;
            r_inst_pc    <= {ADDR_W{1'b0}};
        end else if (w_fetch) begin
            r_inst_valid <= 1'b1;
            r_inst_pc    <= w_fetch_addr;
        end else begin
            r_inst_valid <= r_inst_valid & ~i_inst_ready;
        end
    end

    assign o_inst_valid      = r_inst_valid;
    assign o_inst_data       = i_im_dout;
    assign o_inst_pc         = r_inst_pc;
    assign o_load_full       = r_load_full;
    assign o_running         = w_running;
    assign o_im_address      = w_write ? r_load_ptr : w_fetch_addr;
    assign o_im_enable_mem   = w_fetch | w_write;
    assign o_im_enable_fetch = w_fetch;
    assign o_im_enable_write = w_write;
    assign o_im_din          = i_load_data;

endmodule : instr_fetch_unit
